// File: rtl/ram_cmd_sequencer.sv
// Queued RAM bus master: in-order read/write/masked-write commands issued at up to
// one per clock, read data collected after a fixed latency into a credited response FIFO.
module ram_cmd_sequencer #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned CMD_DEPTH  = 4,
    parameter int unsigned RSP_DEPTH  = 4,
    parameter int unsigned RD_LATENCY = 1,
    localparam int unsigned BE_W      = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [BE_W-1:0]   cmd_be,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              ram_req,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [BE_W-1:0]   ram_be,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);
    localparam int unsigned CPW = $clog2(CMD_DEPTH);
    localparam int unsigned CCW = $clog2(CMD_DEPTH + 1);
    localparam int unsigned RPW = $clog2(RSP_DEPTH);
    localparam int unsigned RCW = $clog2(RSP_DEPTH + 1);
    localparam int unsigned OW  = $clog2(RSP_DEPTH + RD_LATENCY + 2);

    logic              cq_we    [CMD_DEPTH];
    logic [ADDR_W-1:0] cq_addr  [CMD_DEPTH];
    logic [BE_W-1:0]   cq_be    [CMD_DEPTH];
    logic [DATA_W-1:0] cq_wdata [CMD_DEPTH];
    logic [CPW-1:0]    cmd_wr, cmd_rd;
    logic [CCW-1:0]    cmd_cnt, cmd_cnt_n;

    logic [DATA_W-1:0] rq_data [RSP_DEPTH];
    logic [RPW-1:0]    rsp_wr, rsp_rd;
    logic [RCW-1:0]    rsp_cnt, rsp_cnt_n;

    logic [RD_LATENCY-1:0] vld, vld_n;
    logic [OW-1:0]         inflight, occ;

    logic              cmd_push, rsp_push, rsp_pop, issue, credit_ok, head_ok, busy_n;
    logic              head_we;
    logic [ADDR_W-1:0] head_addr;
    logic [BE_W-1:0]   head_be;
    logic [DATA_W-1:0] head_wdata;

    assign cmd_ready = !rst && (cmd_cnt != CCW'(CMD_DEPTH));
    assign cmd_push  = cmd_valid && cmd_ready;
    assign rsp_valid = (rsp_cnt != '0);
    assign rsp_rdata = rsp_valid ? rq_data[rsp_rd] : '0;
    assign rsp_pop   = rsp_valid && rsp_ready;
    assign rsp_push  = vld[RD_LATENCY-1];

    // An empty queue presents the incoming command as its head so accept-to-issue is one cycle.
    assign head_ok    = (cmd_cnt != '0) || cmd_push;
    assign head_we    = (cmd_cnt != '0) ? cq_we[cmd_rd]    : cmd_we;
    assign head_addr  = (cmd_cnt != '0) ? cq_addr[cmd_rd]  : cmd_addr;
    assign head_be    = (cmd_cnt != '0) ? cq_be[cmd_rd]    : cmd_be;
    assign head_wdata = (cmd_cnt != '0) ? cq_wdata[cmd_rd] : cmd_wdata;

    always_comb begin
        inflight = OW'(ram_req && !ram_we);
        for (int unsigned i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + OW'(vld[i]);
        end
        vld_n    = '0;
        vld_n[0] = ram_req && !ram_we;
        for (int unsigned i = 1; i < RD_LATENCY; i++) begin
            vld_n[i] = vld[i-1];
        end
    end

    // Outstanding reads count from the ram_req cycle until popped; a same-cycle pop frees a slot.
    assign occ       = inflight + OW'(rsp_cnt);
    assign credit_ok = (occ - OW'(rsp_pop)) < OW'(RSP_DEPTH);
    assign issue     = head_ok && (head_we || credit_ok);

    assign cmd_cnt_n = cmd_cnt + CCW'(cmd_push) - CCW'(issue);
    assign rsp_cnt_n = rsp_cnt + RCW'(rsp_push) - RCW'(rsp_pop);
    assign busy_n    = (cmd_cnt_n != '0) || (issue && !head_we) || (vld_n != '0) || (rsp_cnt_n != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_wr    <= '0;
            cmd_rd    <= '0;
            cmd_cnt   <= '0;
            rsp_wr    <= '0;
            rsp_rd    <= '0;
            rsp_cnt   <= '0;
            vld       <= '0;
            busy      <= 1'b0;
            ram_req   <= 1'b0;
            ram_we    <= 1'b0;
            ram_be    <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            if (cmd_push) cmd_wr <= cmd_wr + CPW'(1);
            if (issue)    cmd_rd <= cmd_rd + CPW'(1);
            if (rsp_push) rsp_wr <= rsp_wr + RPW'(1);
            if (rsp_pop)  rsp_rd <= rsp_rd + RPW'(1);
            cmd_cnt <= cmd_cnt_n;
            rsp_cnt <= rsp_cnt_n;
            vld     <= vld_n;
            busy    <= busy_n;
            if (issue) begin
                ram_req  <= 1'b1;
                ram_we   <= head_we;
                ram_be   <= head_we ? head_be : '1;
                ram_addr <= head_addr;
                if (head_we) ram_wdata <= head_wdata;
            end else begin
                ram_req <= 1'b0;
                ram_we  <= 1'b0;
                ram_be  <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cmd_push) begin
            cq_we[cmd_wr]    <= cmd_we;
            cq_addr[cmd_wr]  <= cmd_addr;
            cq_be[cmd_wr]    <= cmd_be;
            cq_wdata[cmd_wr] <= cmd_wdata;
        end
        if (rsp_push) rq_data[rsp_wr] <= ram_rdata;
    end
endmodule

// File: tb/tb_ram_cmd_sequencer.sv
// Scoreboard bench for ram_cmd_sequencer: a reference memory updated in accept order
// predicts RAM transactions and read responses; directed phases check timing and credit.
module tb_ram_cmd_sequencer;
    localparam int unsigned AW  = 8;
    localparam int unsigned DW  = 32;
    localparam int unsigned LAT = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0, cmd_we = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [3:0]    cmd_be = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid, rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic          ram_req, ram_we;
    logic [AW-1:0] ram_addr;
    logic [3:0]    ram_be;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic          busy;

    ram_cmd_sequencer #(.ADDR_W(AW), .DATA_W(DW), .CMD_DEPTH(4), .RSP_DEPTH(4), .RD_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
        .cmd_be(cmd_be), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .ram_req(ram_req), .ram_addr(ram_addr), .ram_we(ram_we), .ram_be(ram_be),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_pass = 0;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask
    task automatic fail_now(input string nm);
        n_chk++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Behavioural single-port RAM with fixed read latency; non-read slots carry junk.
    logic [DW-1:0] ram_mem [256];
    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] pipe [LAT];
    assign ram_rdata = pipe[LAT-1];
    initial begin
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = (32'(i) * 32'h0100_0193) ^ 32'h9E37_79B9;
            ref_mem[i] = (32'(i) * 32'h0100_0193) ^ 32'h9E37_79B9;
        end
        for (int i = 0; i < int'(LAT); i++) pipe[i] = '0;
    end
    always @(posedge clk) begin
        if (ram_req && ram_we) begin
            for (int b = 0; b < 4; b++) if (ram_be[b]) ram_mem[ram_addr][8*b +: 8] = ram_wdata[8*b +: 8];
        end
        pipe[0] <= (ram_req && !ram_we) ? ram_mem[ram_addr] : $urandom;
        for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
    end

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [3:0]    be;
        logic [DW-1:0] wdata;
        int            acc;
    } ram_tx_t;
    ram_tx_t       exp_ram[$];
    logic [DW-1:0] exp_rsp[$];
    int            req_cyc[$], rsp_cyc[$], acc_cyc[$];
    logic [DW-1:0] rsp_log[$];
    logic [DW-1:0] last_rsp = '0;
    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(negedge clk) begin
        ram_tx_t t;
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                acc_cyc.push_back(cyc);
                t.we = cmd_we; t.addr = cmd_addr; t.be = cmd_we ? cmd_be : 4'hF;
                t.wdata = cmd_wdata; t.acc = cyc;
                exp_ram.push_back(t);
                if (cmd_we) begin
                    for (int b = 0; b < 4; b++) if (cmd_be[b]) ref_mem[cmd_addr][8*b +: 8] = cmd_wdata[8*b +: 8];
                end else begin
                    exp_rsp.push_back(ref_mem[cmd_addr]);
                end
            end
            if (ram_req) begin
                req_cyc.push_back(cyc);
                if (exp_ram.size() == 0) fail_now("ram_unexpected_req");
                else begin
                    t = exp_ram.pop_front();
                    chk("ram_we", ram_we, t.we);
                    chk("ram_addr", ram_addr, t.addr);
                    chk("ram_be", ram_be, t.be);
                    if (t.we) chk("ram_wdata", ram_wdata, t.wdata);
                    chk("issue_not_early", cyc >= t.acc + 1, 1);
                end
            end else begin
                chk("idle_we_be", {ram_we, ram_be}, 0);
            end
            if (prev_hold) chk("rsp_hold", rsp_rdata, prev_data);
            prev_hold = rsp_valid && !rsp_ready;
            prev_data = rsp_rdata;
            if (rsp_valid && rsp_ready) begin
                rsp_cyc.push_back(cyc);
                rsp_log.push_back(rsp_rdata);
                last_rsp = rsp_rdata;
                if (exp_rsp.size() == 0) fail_now("rsp_unexpected");
                else chk("rsp_rdata", rsp_rdata, exp_rsp.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic we, input logic [AW-1:0] a, input logic [3:0] be, input logic [DW-1:0] d);
        int t;
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_be = be; cmd_wdata = d;
        t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) fail_now("cmd_accept_timeout");
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy || exp_rsp.size() != 0 || exp_ram.size() != 0) && t < 2000) begin
            tick();
            t++;
        end
        chk("drain_idle", {busy, exp_rsp.size() != 0, exp_ram.size() != 0}, 0);
    endtask

    task automatic clear_logs();
        req_cyc.delete(); rsp_cyc.delete(); acc_cyc.delete(); rsp_log.delete();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        cmd_valid = 1'b0;
        repeat (n) tick();
        exp_ram.delete();
        exp_rsp.delete();
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_outputs", {rsp_valid, rsp_rdata, ram_req, ram_addr, ram_we, ram_be, ram_wdata, busy}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", cmd_ready, 1);
        chk("post_rst_quiet", {rsp_valid, busy, ram_req}, 0);
        tick();
    endtask

    bit rnd_done;

    initial begin
        do_reset(3);

        // write then read the same address, back to back
        clear_logs();
        send(1'b1, 8'h10, 4'hF, 32'hDEAD_BEEF);
        send(1'b0, 8'h10, 4'h0, 32'h0);
        wait_idle();
        chk("t1_req_count", req_cyc.size(), 2);
        if (req_cyc.size() >= 2 && acc_cyc.size() >= 2 && rsp_cyc.size() >= 1) begin
            chk("t1_accept_to_req", req_cyc[0], acc_cyc[0] + 1);
            chk("t1_req_back_to_back", req_cyc[1], req_cyc[0] + 1);
            chk("t1_rsp_latency", rsp_cyc[0], req_cyc[1] + int'(LAT) + 1);
        end
        chk("t1_data", last_rsp, 32'hDEAD_BEEF);

        // masked write merges into existing word
        send(1'b1, 8'h20, 4'hF, 32'hAAAA_AAAA);
        send(1'b1, 8'h20, 4'b0101, 32'h1122_3344);
        send(1'b0, 8'h20, 4'h0, 32'h0);
        wait_idle();
        chk("t2_masked", last_rsp, 32'hAA22_AA44);

        // credit limit: 8 reads with consumer stalled
        clear_logs();
        rsp_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(1'b0, 8'h80 + 8'(4 * i), 4'h0, 32'h0);
        repeat (10) tick();
        chk("t3_reads_issued", req_cyc.size(), 4);
        chk("t3_cmd_full", cmd_ready, 0);
        chk("t3_rsp_valid", {rsp_valid, busy}, 2'b11);
        rsp_ready = 1'b1;
        wait_idle();
        chk("t3_rsp_count", rsp_cyc.size(), 8);

        // stalled read blocks writes behind it; release gives 4 gapless issues
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(1'b0, 8'h90 + 8'(4 * i), 4'h0, 32'h0);
        for (int i = 0; i < 3; i++) send(1'b1, 8'h60 + 8'(4 * i), 4'hF, 32'h5000_0000 + 32'(i));
        repeat (3) tick();
        clear_logs();
        repeat (4) tick();
        chk("t4_no_bypass", req_cyc.size(), 0);
        chk("t4_cmd_full", cmd_ready, 0);
        rsp_ready = 1'b1;
        wait_idle();
        chk("t4_req_count", req_cyc.size(), 4);
        if (req_cyc.size() >= 4) chk("t4_gapless", req_cyc[3] - req_cyc[0], 3);

        // read latency on preloaded words
        send(1'b1, 8'h00, 4'hF, 32'd1);
        send(1'b1, 8'h04, 4'hF, 32'd2);
        send(1'b1, 8'h08, 4'hF, 32'd3);
        wait_idle();
        clear_logs();
        send(1'b0, 8'h00, 4'h0, 32'h0);
        send(1'b0, 8'h04, 4'h0, 32'h0);
        send(1'b0, 8'h08, 4'h0, 32'h0);
        wait_idle();
        chk("t5_rsp_count", rsp_log.size(), 3);
        if (rsp_log.size() >= 3 && req_cyc.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("t5_rsp_lat", rsp_cyc[i] - req_cyc[i], int'(LAT) + 1);
                chk("t5_rsp_val", rsp_log[i], 32'(i + 1));
            end
        end

        // reset while a read is in flight
        send(1'b1, 8'h30, 4'hF, 32'hCAFE_F00D);
        wait_idle();
        send(1'b0, 8'h30, 4'h0, 32'h0);
        chk("t6_req_seen", ram_req, 1);
        tick();
        do_reset(2);
        repeat (5) tick();
        chk("t6_discarded", {rsp_valid, busy}, 0);
        send(1'b0, 8'h30, 4'h0, 32'h0);
        wait_idle();
        chk("t6_new_read", last_rsp, 32'hCAFE_F00D);

        // randomized traffic with a throttled consumer
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 120; i++) begin
                    send(1'($urandom_range(0, 1)), 8'hC0 + 8'(4 * $urandom_range(0, 15)),
                         4'($urandom), $urandom);
                    repeat ($urandom_range(0, 2)) tick();
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    rsp_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
            end
        join
        rsp_ready = 1'b1;
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ram_cmd_sequencer.md
Name: ram_cmd_sequencer

Overview:
- Synthesizable, parametrised RAM bus master. It replaces task-driven single-transaction access with a queued command stream.
- Accepts read, write and masked-write commands over a valid/ready channel and issues them in order on the RAM port, up to one transaction per clock.
- Collects read data after a fixed RAM latency into a response FIFO.
- Sits between a traffic source (DMA, test sequencer, debug bridge) and a single-port synchronous RAM with req/addr/we/be/wdata/rdata signalling.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width. Must be a multiple of 8. Byte-enable width BE_W = DATA_W/8 is derived.
- CMD_DEPTH, 4, command FIFO entries. Power of 2, ≥2.
- RSP_DEPTH, 4, response FIFO entries. Power of 2, ≥2.
- RD_LATENCY, 1, cycles from the ram_req cycle to the ram_rdata-valid cycle. Legal range 1..4.

Ports:
- clk  in  1  clock. All logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command FIFO can accept.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_be  in  BE_W  byte enables. Ignored for reads; reads always issue all-ones.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer accepts read data.
- rsp_rdata  out  DATA_W  read data, in read-issue order.
- ram_req  out  1  RAM request strobe, one cycle per transaction.
- ram_addr  out  ADDR_W  RAM address.
- ram_we  out  1  RAM write enable.
- ram_be  out  BE_W  RAM byte enables.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data.
- busy  out  1  any command queued, read in flight, or response unread.

Behaviour:
Handshakes and reset
- Command transfer occurs on a rising edge with cmd_valid && cmd_ready.
- cmd_ready = !cmd_full, driven from registered occupancy. When full, cmd_ready is 0 and a simultaneous pop does not enable a push in the same cycle.
- Response transfer occurs on rsp_valid && rsp_ready. rsp_valid = !rsp_empty. rsp_rdata shows the FIFO head, stable while rsp_valid && !rsp_ready.
- Reset values: cmd_ready 0 while rst is high, 1 in the first cycle after. All other outputs 0 (rsp_valid, rsp_rdata, ram_req, ram_addr, ram_we, ram_be, ram_wdata, busy).
- Reset mid-operation empties both FIFOs and clears the in-flight pipeline. ram_rdata returning for reads issued before reset is discarded.

Issue stage
- Fully registered. A command accepted at edge E can drive ram_req in the cycle after E at the earliest. Latency from accept to ram_req is one cycle.
- Each cycle the issue stage evaluates the FIFO head:
  - Head is a write: pop it, drive ram_req=1, ram_we=1, ram_be=cmd_be, ram_addr, ram_wdata for exactly one cycle.
  - Head is a read and credit > 0: pop it, drive ram_req=1, ram_we=0, ram_be=all-ones, ram_addr for exactly one cycle.
  - Head is a read and credit = 0: stall. Commands behind it also stall; strict order, no bypass.
- Back-to-back issue is allowed. N queued issuable commands produce N consecutive ram_req cycles.
- Idle cycles: ram_req=0, ram_we=0, ram_be=0. ram_addr and ram_wdata hold their last values.
- A write with cmd_be=0 is still issued (ram_req=1, ram_be=0). The RAM performs no store.

Read return
- Credit = RSP_DEPTH − (reads in flight + response FIFO occupancy). Credit is updated in the same cycle as issue, push and pop. A pop in cycle N allows a read issue in cycle N.
- A valid-bit shift register of length RD_LATENCY tracks reads. A read with ram_req in cycle N has ram_rdata sampled at the end of cycle N+RD_LATENCY and pushed to the response FIFO. rsp_valid rises in cycle N+RD_LATENCY+1.
- The response FIFO never overflows because of credit. A push and pop in the same cycle while full is impossible by construction. A push and pop in the same cycle while non-empty keeps occupancy unchanged.

busy
- busy = !cmd_empty || any in-flight bit || !rsp_empty, registered.

Test Plan:
- Reset, then write addr 0x10 data 0xDEADBEEF, then read 0x10 (RD_LATENCY=1), rsp_ready=1 → ram_req in cycles 1 and 2. Second ram_req has ram_we=0, ram_be=0xF. rsp_valid in cycle 4 with rsp_rdata=0xDEADBEEF; busy falls afterwards.
- Masked write 0x20 data 0x11223344 be=4'b0101 over an initial 0xAAAAAAAA, then read → 0xAA22AA44.
- 8 reads queued, rsp_ready=0, RSP_DEPTH=4 → exactly 4 ram_req. Issue stalls with cmd FIFO full and cmd_ready=0. Raising rsp_ready resumes issue; 8 responses arrive in address order.
- 4 back-to-back writes from a full cmd FIFO → 4 consecutive ram_req cycles with no gaps. Idle ram_be=0 before and after.
- RD_LATENCY=3, reads of 0x0/0x4/0x8 preloaded 1/2/3 → responses 1,2,3 appear 4 cycles after their respective ram_req cycles.
- rst asserted one cycle after a read's ram_req (RD_LATENCY=2) → rsp_valid stays 0, busy 0, cmd_ready 1 after reset. A new read returns correct data.
